// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub, shift-add multiply and restoring
// divide/modulo, one bit per cycle, with a start/busy/done handshake.
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   inputA,
  input  logic [WIDTH-1:0]   inputB,
  input  logic [3:0]         command,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               error
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_MOD = 4'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_op, b_op;
  logic [3:0]         cmd_op;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;

  logic               accept, iterative, last_iter;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic               ovf;
  logic [2*WIDTH-1:0] single_res;
  logic               single_err;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] iter_acc;
  logic [2*WIDTH-1:0] iter_res;

  // FINISH is not busy, so a start there is taken back-to-back.
  assign accept    = start && (state != CALC);
  assign iterative = (command == OP_MUL) ||
                     (((command == OP_DIV) || (command == OP_MOD)) && (inputB != '0));
  assign last_iter = (state == CALC) && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CALC:    if (last_iter) state_next = FINISH;
      default: begin
        if (accept) state_next = iterative ? CALC : FINISH;
        else        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == FINISH);
  end

  // Single-step operations work straight off the ports in the accepting cycle.
  always_comb begin
    addend     = (command == OP_SUB) ? ~inputB : inputB;
    sum        = {1'b0, inputA} + {1'b0, addend} + {{WIDTH{1'b0}}, (command == OP_SUB)};
    ovf        = sum[WIDTH] ^ (inputA[WIDTH-1] ^ addend[WIDTH-1] ^ sum[WIDTH-1]);
    single_res = '0;
    single_err = 1'b0;
    case (command)
      OP_ADD, OP_SUB: begin
        single_res = {{WIDTH{sum[WIDTH-1]}}, sum[WIDTH-1:0]};
        single_err = ovf;
      end
      OP_DIV: begin
        single_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
        single_err = 1'b1;
      end
      OP_MOD: begin
        single_res = {{WIDTH{1'b0}}, inputA};
        single_err = 1'b1;
      end
      default: ;
    endcase
  end

  // acc holds {partial product, multiplier} for mul, {remainder, dividend/quotient} for div.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_op} : '0);
    div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_sub  = div_part[WIDTH-1:0] - b_op;
    if (cmd_op == OP_MUL)
      iter_acc = {mul_sum, acc[WIDTH-1:1]};
    else if (div_part >= {1'b0, b_op})
      iter_acc = {rem_sub, acc[WIDTH-2:0], 1'b1};
    else
      iter_acc = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    case (cmd_op)
      OP_MUL:  iter_res = iter_acc;
      OP_DIV:  iter_res = {{WIDTH{1'b0}}, iter_acc[WIDTH-1:0]};
      default: iter_res = {{WIDTH{1'b0}}, iter_acc[2*WIDTH-1:WIDTH]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_op   <= '0;
      b_op   <= '0;
      cmd_op <= '0;
      count  <= '0;
      acc    <= '0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      if (accept) begin
        a_op   <= inputA;
        b_op   <= inputB;
        cmd_op <= command;
        count  <= '0;
        acc    <= {{WIDTH{1'b0}}, (command == OP_MUL) ? inputB : inputA};
      end else if (state == CALC) begin
        acc   <= iter_acc;
        count <= count + CW'(1);
      end
      if (accept && !iterative) begin
        result <= single_res;
        error  <= single_err;
      end else if (last_iter) begin
        result <= iter_res;
        error  <= 1'b0;
      end
    end
  end

endmodule
